// File: rtl/snn_fanout_walker_if.sv
// Bundle for the fan-out walker: request channel from the spike scheduler,
// edge stream to the membrane accumulator, and the weight-update port.
interface snn_fanout_walker_if #(
  parameter int ID_W     = 6,
  parameter int IDX_W    = 2,
  parameter int WEIGHT_W = 16
);
  localparam int ADDR_W = ID_W + IDX_W;

  // Handshake rule for req_* and out_*: a transfer happens on a rising edge
  // where valid && ready; the sender holds valid and payload stable until then.
  logic                       req_valid;
  logic                       req_ready;
  logic [ID_W-1:0]            req_src_id;
  logic                       req_skip_zero;

  logic                       out_valid;
  logic                       out_ready;
  logic [ID_W-1:0]            out_dst_id;
  logic signed [WEIGHT_W-1:0] out_weight;
  logic [ADDR_W-1:0]          out_addr;
  logic                       out_last;

  logic                       upd_valid_i;
  logic                       upd_ready_o;
  logic [ADDR_W-1:0]          upd_addr_i;
  logic signed [WEIGHT_W-1:0] upd_dw_i;

  modport slave (
    input  req_valid, req_src_id, req_skip_zero, out_ready,
           upd_valid_i, upd_addr_i, upd_dw_i,
    output req_ready, out_valid, out_dst_id, out_weight, out_addr, out_last,
           upd_ready_o
  );

  modport master (
    output req_valid, req_src_id, req_skip_zero, out_ready,
           upd_valid_i, upd_addr_i, upd_dw_i,
    input  req_ready, out_valid, out_dst_id, out_weight, out_addr, out_last,
           upd_ready_o
  );
endinterface

// File: rtl/snn_fanout_walker.sv
// Walks the FANOUT outgoing synapses of one source neuron, streaming one edge
// per handshake, with an optional zero-weight skip and saturating weight updates.
module snn_fanout_walker #(
  parameter int N_NEURON = 64,
  parameter int FANOUT   = 4,
  parameter int DST_BASE = N_NEURON - FANOUT,
  parameter int WEIGHT_W = 16,
  parameter int W_INIT   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  snn_fanout_walker_if.slave  bus,
  output logic                done_o,
  output logic                state_o
);
  localparam int ID_W   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam int IDX_W  = $clog2(FANOUT);
  localparam int ADDR_W = ID_W + IDX_W;
  // Rows for IDs at or above N_NEURON are never addressed by a legal request.
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(FANOUT - 1);
  localparam logic signed [WEIGHT_W-1:0] W_RST    = WEIGHT_W'(W_INIT);
  localparam logic signed [WEIGHT_W-1:0] W_MAX    = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN    = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_WALK = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            src_q, src_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       skip_q, skip_d;
  logic                       done_q, done_d;

  logic signed [WEIGHT_W-1:0] w_q [DEPTH];

  logic [ADDR_W-1:0]          cur_addr;
  logic signed [WEIGHT_W-1:0] cur_w;
  logic                       cur_skip;
  logic                       rest_zero;
  logic                       beat_valid;
  logic                       req_ok;
  logic                       advance;
  logic signed [WEIGHT_W:0]   upd_sum;
  logic signed [WEIGHT_W-1:0] upd_sat;

  assign cur_addr   = {src_q, idx_q};
  assign cur_w      = w_q[cur_addr];
  assign cur_skip   = (state_q == S_WALK) && skip_q && (cur_w == '0);
  assign beat_valid = clk_en && (state_q == S_WALK) && !cur_skip;
  assign req_ok     = clk_en && (state_q == S_IDLE);
  assign advance    = clk_en && (state_q == S_WALK) &&
                      ((beat_valid && bus.out_ready) || cur_skip);

  // True when every edge after the current one would be skipped as zero.
  always_comb begin
    rest_zero = 1'b1;
    for (int j = 0; j < FANOUT; j++) begin
      if ((IDX_W'(j) > idx_q) && (w_q[{src_q, IDX_W'(j)}] != '0)) begin
        rest_zero = 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ok;
  assign bus.out_valid   = beat_valid;
  assign bus.out_last    = beat_valid && ((idx_q == LAST_IDX) || (skip_q && rest_zero));
  assign bus.out_weight  = cur_w;
  assign bus.out_dst_id  = ID_W'(DST_BASE) + ID_W'(idx_q);
  assign bus.out_addr    = cur_addr;
  assign bus.upd_ready_o = 1'b1;
  assign done_o          = done_q;
  assign state_o         = state_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    skip_d  = skip_q;
    done_d  = clk_en ? 1'b0 : done_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ok) begin
          src_d   = bus.req_src_id;
          idx_d   = '0;
          skip_d  = bus.req_skip_zero;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      idx_q   <= '0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
    end
  end

  // One guard bit is enough to detect overflow of a two-operand signed add.
  always_comb begin
    upd_sum = {w_q[bus.upd_addr_i][WEIGHT_W-1], w_q[bus.upd_addr_i]} +
              {bus.upd_dw_i[WEIGHT_W-1], bus.upd_dw_i};
    upd_sat = upd_sum[WEIGHT_W-1:0];
    if (upd_sum[WEIGHT_W] != upd_sum[WEIGHT_W-1]) begin
      upd_sat = upd_sum[WEIGHT_W] ? W_MIN : W_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_q[i] <= W_RST;
      end
    end else if (clk_en && bus.upd_valid_i) begin
      w_q[bus.upd_addr_i] <= upd_sat;
    end
  end
endmodule

// File: tb/tb_snn_fanout_walker.sv
// Directed bench for snn_fanout_walker: a weight/beat model predicts each walk,
// and a negedge compare process checks every presented beat against it.
module tb_snn_fanout_walker;
  localparam int N    = 64;
  localparam int F    = 4;
  localparam int WW   = 16;
  localparam int IDW  = 6;
  localparam int IXW  = 2;
  localparam int AW   = IDW + IXW;
  localparam int BASE = N - F;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic done_o;
  logic state_o;

  snn_fanout_walker_if #(.ID_W(IDW), .IDX_W(IXW), .WEIGHT_W(WW)) bus ();

  snn_fanout_walker #(
    .N_NEURON(N), .FANOUT(F), .DST_BASE(BASE), .WEIGHT_W(WW), .W_INIT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus),
    .done_o(done_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  typedef struct {
    int dst;
    int addr;
    int w;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    model_w [N*F];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N*F; i++) model_w[i] = 64;
  endfunction

  function automatic void model_update(int a, int dw);
    int s;
    s = model_w[a] + dw;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    model_w[a] = s;
  endfunction

  // The walk emits, in order, every edge of src that is not skipped;
  // the final emitted edge is flagged last.
  function automatic void build_q(int src, bit skip);
    beat_t b;
    exp_q.delete();
    for (int j = 0; j < F; j++) begin
      if (skip && model_w[src*F + j] == 0) continue;
      b.dst  = BASE + j;
      b.addr = src*F + j;
      b.w    = model_w[src*F + j];
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1) begin
        check("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("out_dst_id", int'(bus.out_dst_id), exp_q[0].dst);
          check("out_addr",   int'(bus.out_addr),   exp_q[0].addr);
          check("out_weight", int'($signed(bus.out_weight)), exp_q[0].w);
          check("out_last",   int'(bus.out_last),   int'(exp_q[0].last));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_last_idle", int'(bus.out_last), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_update(input int a, input int dw);
    bus.upd_valid_i = 1'b1;
    bus.upd_addr_i  = AW'(a);
    bus.upd_dw_i    = WW'(dw);
    model_update(a, dw);
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b0;
  endtask

  // pat=1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic do_walk(input int src, input bit skip, input int pat,
                         input int upd_cyc, input int upd_a, input int upd_dw,
                         input int lit_beats, input int lit_first_w,
                         input int lit_last_dst, input int lit_done_cyc);
    int cyc;
    bit seen;
    build_q(src, skip);
    check("model_beats", exp_q.size(), lit_beats);
    if (exp_q.size() > 0) begin
      check("model_first_w", exp_q[0].w, lit_first_w);
      check("model_last_dst", exp_q[exp_q.size()-1].dst, lit_last_dst);
    end
    bus.req_valid     = 1'b1;
    bus.req_src_id    = IDW'(src);
    bus.req_skip_zero = skip;
    bus.out_ready     = 1'b0;
    @(negedge clk);
    check("req_ready", int'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      bus.out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (cyc == upd_cyc) begin
        bus.upd_valid_i = 1'b1;
        bus.upd_addr_i  = AW'(upd_a);
        bus.upd_dw_i    = WW'(upd_dw);
        model_update(upd_a, upd_dw);
      end
      @(negedge clk);
      if (done_o === 1'b1) seen = 1'b1;
      else cyc++;
      @(posedge clk); #1;
      bus.upd_valid_i = 1'b0;
    end
    check("done_cycle", seen ? cyc : -1, lit_done_cyc);
    @(negedge clk);
    check("done_pulse_width", int'(done_o), 0);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n             = 1'b0;
    clk_en            = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_src_id    = '0;
    bus.req_skip_zero = 1'b0;
    bus.out_ready     = 1'b0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_addr_i    = '0;
    bus.upd_dw_i      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    check("rst_done",      int'(done_o), 0);
    check("rst_state",     int'(state_o), 0);
    check("upd_ready",     int'(bus.upd_ready_o), 1);
    @(posedge clk); #1;

    // Plain walk, then the same walk under back-pressure.
    do_walk(5, 1'b0, 0, -1, 0, 0, 4, 64, 63, 4);
    do_walk(5, 1'b0, 1, -1, 0, 0, 4, 64, 63, 8);

    // Zero-skip with a hole, then with a trailing zero.
    do_update(21, -64);
    do_walk(5, 1'b1, 0, -1, 0, 0, 3, 64, 63, 4);
    do_update(23, -64);
    do_walk(5, 1'b1, 0, -1, 0, 0, 2, 64, 62, 4);

    // Saturation at both rails.
    do_update(0, 32767);
    do_update(0, 32767);
    check("model_sat_hi", model_w[0], 32767);
    do_walk(0, 1'b0, 0, -1, 0, 0, 4, 32767, 63, 4);
    do_update(0, -32768);
    do_update(0, -32768);
    do_update(0, -32768);
    check("model_sat_lo", model_w[0], -32768);
    do_walk(0, 1'b0, 0, -1, 0, 0, 4, -32768, 63, 4);

    // Update colliding with the handshake of the same synapse.
    do_walk(5, 1'b0, 0, 0, 20, 10, 4, 64, 63, 4);
    do_walk(5, 1'b0, 0, -1, 0, 0, 4, 74, 63, 4);

    // Freeze mid-walk with clk_en low, then reset mid-walk.
    build_q(5, 1'b0);
    bus.req_valid     = 1'b1;
    bus.req_src_id    = IDW'(5);
    bus.req_skip_zero = 1'b0;
    bus.out_ready     = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    clk_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("frozen_out_valid", int'(bus.out_valid), 0);
      check("frozen_req_ready", int'(bus.req_ready), 0);
      check("frozen_state",     int'(state_o), 1);
      @(posedge clk); #1;
    end
    clk_en        = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("resume_state", int'(state_o), 1);
    check("resume_queue", exp_q.size(), 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_state",     int'(state_o), 0);
    check("abort_done",      int'(done_o), 0);
    check("abort_req_ready", int'(bus.req_ready), 1);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_reset", int'(done_o), 0);
      @(posedge clk); #1;
    end

    // Weights are back at their reset value.
    do_walk(5, 1'b1, 0, -1, 0, 0, 4, 64, 63, 4);
    do_walk(0, 1'b0, 0, -1, 0, 0, 4, 64, 63, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
